// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of the shared 256x16 memory with a start/ready handshake.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_rwn,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_start,
  output logic              mem_rwn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready,
  output logic              busy,
  output logic              tmo_err
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic               gnt_data_q;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic [DATA_W-1:0]  if_rdata_q;
  logic [DATA_W-1:0]  d_rdata_q;
  logic               if_done_q;
  logic               d_done_q;
  logic               mem_start_q;
  logic               mem_rwn_q;
  logic [ADDR_W-1:0]  mem_address_q;
  logic [DATA_W-1:0]  mem_data_in_q;
  logic               busy_q;
  logic               tmo_err_q;
  logic               pick_data;

`ifdef MEM_ARB_RR_EN
  // prio_data_q set means the data port wins the next contention.
  logic prio_data_q;
  assign pick_data = d_req & (~if_req | prio_data_q);
`else
  assign pick_data = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      gnt_data_q    <= 1'b0;
      tmo_cnt_q     <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_done_q     <= 1'b0;
      d_done_q      <= 1'b0;
      mem_start_q   <= 1'b0;
      mem_rwn_q     <= 1'b1;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      busy_q        <= 1'b0;
      tmo_err_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      prio_data_q   <= 1'b1;
`endif
    end else begin
      mem_start_q <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req | d_req) begin
            gnt_data_q <= pick_data;
            if (pick_data) begin
              mem_rwn_q     <= d_rwn;
              mem_address_q <= d_addr;
              mem_data_in_q <= d_wdata;
            end else begin
              mem_rwn_q     <= 1'b1;
              mem_address_q <= if_addr;
              mem_data_in_q <= '0;
            end
`ifdef MEM_ARB_RR_EN
            prio_data_q <= ~pick_data;
`endif
            mem_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt_q <= '0;
          state_q   <= S_BUSY;
        end
        S_BUSY: begin
          if (mem_ready) begin
            if (mem_rwn_q) begin
              if (gnt_data_q) d_rdata_q  <= mem_data_out;
              else            if_rdata_q <= mem_data_out;
            end
            d_done_q  <= gnt_data_q;
            if_done_q <= ~gnt_data_q;
            state_q   <= S_DONE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Abort: a read that never completed returns zero data.
            tmo_err_q <= 1'b1;
            if (mem_rwn_q) begin
              if (gnt_data_q) d_rdata_q  <= '0;
              else            if_rdata_q <= '0;
            end
            d_done_q  <= gnt_data_q;
            if_done_q <= ~gnt_data_q;
            state_q   <= S_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_done     = if_done_q;
  assign d_rdata     = d_rdata_q;
  assign d_done      = d_done_q;
  assign mem_start   = mem_start_q;
  assign mem_rwn     = mem_rwn_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign busy        = busy_q;
  assign tmo_err     = tmo_err_q;

endmodule
